wmma_scatter_ctrl: RTL and testbench
====================================

WMMA_SCATTER_CTRL -- requirements
Module: wmma_scatter_ctrl

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  tensor result available.
- in_ready  out  1  controller can accept a result.
- in_rD  in  4  destination base GPR.
- in_mask  in  4  per-thread active mask; bit t = SP TID t.
- in_data  in  256  4x4 BF16/INT16 result; row t, column c at bits [(t*4+c)*16 +: 16].
- w1_addr, w2_addr, w3_addr  out  16 each  per-thread GPR external write address; thread t at [t*4 +: 4].
- w1_data, w2_data, w3_data  out  64 each  per-thread write data; thread t at [t*16 +: 16].
- w1_we, w2_we, w3_we  out  4 each  per-thread write enable.
- busy  out  1  scatter in progress.
- done  out  1  one-cycle completion pulse.
- sb_clr_mask  out  16  scoreboard clear bits for the destination GPRs.

Function
REQ-002 SHALL implement FSM states IDLE, BEAT0, BEAT1, DONE.
REQ-003 SHALL drive in_ready=1 in IDLE and DONE, and in_ready=0 in BEAT0 and BEAT1.
REQ-004 SHALL accept a result on a rising edge where in_valid&in_ready; at that edge it SHALL latch in_rD, in_mask and in_data and go to BEAT0.
REQ-005 SHALL ignore in_data, in_rD and in_mask when no accept occurs; latched values SHALL stay stable until the next accept.
REQ-006 In BEAT0, for each thread t, SHALL drive:
- w1: addr=rD, data=row t col 0.
- w2: addr=rD+1, data=row t col 1.
- w3: addr=rD+2, data=row t col 2.
- wK_we[t]=mask[t].
REQ-007 In BEAT1, for each thread t, SHALL drive w1 addr=rD+3, data=row t col 3, w1_we[t]=mask[t], and w2_we=w3_we=0.
REQ-008 All address offsets SHALL be computed modulo 16 (rD=14 -> addresses 14, 15, 0, 1).
REQ-009 In IDLE and DONE, all wK_we SHALL be 0; addr/data values are don't-care.
REQ-010 Transitions SHALL be: BEAT0 -> BEAT1 unconditionally; BEAT1 -> DONE unconditionally; DONE -> BEAT0 on accept, else IDLE.
REQ-011 SHALL assert done=1 only in DONE.
REQ-012 SHALL assert busy=1 in BEAT0, BEAT1 and DONE.
REQ-013 Latency SHALL be: accept at edge N -> BEAT0 writes in cycle N+1, BEAT1 writes in N+2, done in N+3.
REQ-014 Sustained throughput SHALL be one result per 3 cycles (back-to-back accept in DONE).
REQ-015 With in_mask=0, SHALL still sequence all states and pulse done with no write enables asserted.
REQ-016 Write enables SHALL NOT depend on any pipeline stall; the scoreboard guarantees no W0 writes to rD..rD+3 while busy.
REQ-017 All outputs SHALL be decoded from the state register and latched registers only, with no combinational path from inputs except none (in_ready depends on state only).

Reset
REQ-018 On rst_n low, SHALL asynchronously enter IDLE and clear the latched registers to 0.
REQ-019 During reset, outputs SHALL be: in_ready=1, busy=0, done=0, all we=0, sb_clr_mask=0.
REQ-020 Reset asserted mid-scatter SHALL abort it immediately; no further write enables and no done pulse for that result.

Configuration
REQ-021 Macro WMMA_SCATTER_SB_CLR_EN SHALL control sb_clr_mask.
- Defined: sb_clr_mask SHALL have bits rD, rD+1, rD+2, rD+3 (mod 16) set in the DONE cycle and be 0 otherwise.
- Undefined: sb_clr_mask SHALL be tied to 0.
- The port SHALL exist in both builds.

Verification
REQ-022 rD=4, mask=1111, data[row t col c] = 16'h(t)(c)00 -> cycle N+1: w1/w2/w3 write regs 4/5/6 with cols 0..2 on all threads; cycle N+2: w1 writes reg 7 with col 3; done at N+3.
REQ-023 rD=14, mask=1111 -> addresses 14, 15, 0, 1; with macro defined, sb_clr_mask=16'hC003 in the DONE cycle.
REQ-024 mask=0101 -> only we bits 0 and 2 asserted in both beats; mask=0000 -> no writes and done still pulses at N+3.
REQ-025 in_valid held high for 3 results -> accepts at N, N+3, N+6; in_ready low in BEAT0/BEAT1; second result's data is not corrupted by in_data changing during beats.
REQ-026 rst_n pulsed low during BEAT1 -> all we=0 immediately, no done pulse, in_ready=1; next accept behaves normally.

Source files
------------

// File: rtl/wmma_scatter_ctrl.sv
// Scatters a 4x4 WMMA tensor result into per-thread GPRs over two write beats.
// Optional macro WMMA_SCATTER_SB_CLR_EN drives sb_clr_mask for the destination GPRs in the DONE cycle.
module wmma_scatter_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_rD,
  input  logic [3:0]   in_mask,
  input  logic [255:0] in_data,
  output logic [15:0]  w1_addr,
  output logic [15:0]  w2_addr,
  output logic [15:0]  w3_addr,
  output logic [63:0]  w1_data,
  output logic [63:0]  w2_data,
  output logic [63:0]  w3_data,
  output logic [3:0]   w1_we,
  output logic [3:0]   w2_we,
  output logic [3:0]   w3_we,
  output logic         busy,
  output logic         done,
  output logic [15:0]  sb_clr_mask
);

  // state | meaning
  // IDLE  | waiting for a result
  // BEAT0 | write cols 0..2 to rD..rD+2
  // BEAT1 | write col 3 to rD+3
  // DONE  | completion pulse; may accept the next result
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    rd_q;
  logic [3:0]    mask_q;
  logic [255:0]  data_q;
  logic          accept;
  logic [3:0]    rd1, rd2, rd3;

  assign accept = in_valid & in_ready;
  assign rd1 = rd_q + 4'd1;
  assign rd2 = rd_q + 4'd2;
  assign rd3 = rd_q + 4'd3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rd_q   <= '0;
      mask_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rd_q   <= in_rD;
        mask_q <= in_mask;
        data_q <= in_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE) || (state == DONE);
    busy      = (state != IDLE);
    done      = (state == DONE);
    w1_addr   = '0;
    w2_addr   = '0;
    w3_addr   = '0;
    w1_data   = '0;
    w2_data   = '0;
    w3_data   = '0;
    w1_we     = '0;
    w2_we     = '0;
    w3_we     = '0;
    case (state)
      IDLE: if (in_valid) state_nxt = BEAT0;
      BEAT0: begin
        state_nxt = BEAT1;
        for (int t = 0; t < 4; t++) begin
          w1_addr[t*4 +: 4]  = rd_q;
          w2_addr[t*4 +: 4]  = rd1;
          w3_addr[t*4 +: 4]  = rd2;
          w1_data[t*16 +: 16] = data_q[(t*4+0)*16 +: 16];
          w2_data[t*16 +: 16] = data_q[(t*4+1)*16 +: 16];
          w3_data[t*16 +: 16] = data_q[(t*4+2)*16 +: 16];
        end
        w1_we = mask_q;
        w2_we = mask_q;
        w3_we = mask_q;
      end
      BEAT1: begin
        state_nxt = DONE;
        for (int t = 0; t < 4; t++) begin
          w1_addr[t*4 +: 4]  = rd3;
          w1_data[t*16 +: 16] = data_q[(t*4+3)*16 +: 16];
        end
        w1_we = mask_q;
      end
      DONE: state_nxt = in_valid ? BEAT0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef WMMA_SCATTER_SB_CLR_EN
  always_comb begin
    sb_clr_mask = '0;
    if (state == DONE)
      sb_clr_mask = (16'h0001 << rd_q) | (16'h0001 << rd1) |
                    (16'h0001 << rd2) | (16'h0001 << rd3);
  end
`else
  assign sb_clr_mask = '0;
`endif

endmodule

// File: tb/tb_wmma_scatter_ctrl.sv
// Directed self-checking bench for wmma_scatter_ctrl; samples outputs 1 time unit after each rising edge.
module tb_wmma_scatter_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_rD;
  logic [3:0]   in_mask;
  logic [255:0] in_data;
  logic [15:0]  w1_addr, w2_addr, w3_addr;
  logic [63:0]  w1_data, w2_data, w3_data;
  logic [3:0]   w1_we, w2_we, w3_we;
  logic         busy, done;
  logic [15:0]  sb_clr_mask;

  int vectors = 0;
  int errs = 0;

  wmma_scatter_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rD(in_rD), .in_mask(in_mask), .in_data(in_data),
    .w1_addr(w1_addr), .w2_addr(w2_addr), .w3_addr(w3_addr),
    .w1_data(w1_data), .w2_data(w2_data), .w3_data(w3_data),
    .w1_we(w1_we), .w2_we(w2_we), .w3_we(w3_we),
    .busy(busy), .done(done), .sb_clr_mask(sb_clr_mask)
  );

  always #5 clk = ~clk;

  // row t, column c holds {t, c, lo}
  function automatic logic [255:0] pat(input logic [7:0] lo);
    logic [255:0] v;
    v = '0;
    for (int t = 0; t < 4; t++)
      for (int c = 0; c < 4; c++)
        v[(t*4+c)*16 +: 16] = {4'(t), 4'(c), lo};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ready"}, 64'(in_ready), 64'd1);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " we"}, 64'({w1_we, w2_we, w3_we}), 64'd0);
  endtask

  task automatic chk_done(input string tag, input logic [15:0] sb_exp);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " busy"}, 64'(busy), 64'd1);
    chk({tag, " ready"}, 64'(in_ready), 64'd1);
    chk({tag, " we"}, 64'({w1_we, w2_we, w3_we}), 64'd0);
`ifdef WMMA_SCATTER_SB_CLR_EN
    chk({tag, " sb"}, 64'(sb_clr_mask), 64'(sb_exp));
`else
    chk({tag, " sb"}, 64'(sb_clr_mask), 64'h0);
    if (sb_exp == 16'hFFFF) $display("unused");
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_rD = '0;
    in_mask = '0;
    in_data = '0;
    #2;
    chk_idle("rst");
    chk("rst sb", 64'(sb_clr_mask), 64'h0);
    step();
    rst_n = 1'b1;
    step();
    chk_idle("idle");

    // rD=4, full mask; inputs garbled during beats
    in_valid = 1'b1; in_rD = 4'd4; in_mask = 4'hF; in_data = pat(8'h00);
    step();
    in_valid = 1'b0; in_rD = 4'd9; in_mask = 4'h0; in_data = ~pat(8'h00);
    chk("b0 ready", 64'(in_ready), 64'd0);
    chk("b0 busy", 64'(busy), 64'd1);
    chk("b0 done", 64'(done), 64'd0);
    chk("b0 w1a", 64'(w1_addr), 64'h4444);
    chk("b0 w2a", 64'(w2_addr), 64'h5555);
    chk("b0 w3a", 64'(w3_addr), 64'h6666);
    chk("b0 w1d", w1_data, 64'h3000_2000_1000_0000);
    chk("b0 w2d", w2_data, 64'h3100_2100_1100_0100);
    chk("b0 w3d", w3_data, 64'h3200_2200_1200_0200);
    chk("b0 we", 64'({w1_we, w2_we, w3_we}), 64'hFFF);
    step();
    chk("b1 ready", 64'(in_ready), 64'd0);
    chk("b1 w1a", 64'(w1_addr), 64'h7777);
    chk("b1 w1d", w1_data, 64'h3300_2300_1300_0300);
    chk("b1 we", 64'({w1_we, w2_we, w3_we}), 64'hF00);
    step();
    chk_done("d4", 16'h00F0);
    step();
    chk_idle("post4");

    // rD=14 wraps
    in_valid = 1'b1; in_rD = 4'd14; in_mask = 4'hF; in_data = pat(8'h00);
    step();
    in_valid = 1'b0;
    chk("w14 w1a", 64'(w1_addr), 64'hEEEE);
    chk("w14 w2a", 64'(w2_addr), 64'hFFFF);
    chk("w14 w3a", 64'(w3_addr), 64'h0000);
    step();
    chk("w14 b1 w1a", 64'(w1_addr), 64'h1111);
    step();
    chk_done("d14", 16'hC003);
    step();

    // partial mask 0101
    in_valid = 1'b1; in_rD = 4'd2; in_mask = 4'b0101;
    step();
    in_valid = 1'b0;
    chk("m5 b0 we", 64'({w1_we, w2_we, w3_we}), 64'h555);
    step();
    chk("m5 b1 we", 64'({w1_we, w2_we, w3_we}), 64'h500);
    step();
    chk_done("dm5", 16'h003C);
    step();

    // empty mask still sequences
    in_valid = 1'b1; in_rD = 4'd0; in_mask = 4'b0000;
    step();
    in_valid = 1'b0;
    chk("m0 b0 we", 64'({w1_we, w2_we, w3_we}), 64'h000);
    chk("m0 b0 busy", 64'(busy), 64'd1);
    step();
    chk("m0 b1 we", 64'({w1_we, w2_we, w3_we}), 64'h000);
    chk("m0 b1 done", 64'(done), 64'd0);
    step();
    chk_done("dm0", 16'h000F);
    step();
    chk_idle("postm0");

    // back-to-back: accepts at N, N+3, N+6
    in_valid = 1'b1; in_rD = 4'd1; in_mask = 4'hF; in_data = pat(8'h00);
    step();
    in_rD = 4'd9; in_data = ~pat(8'h00);
    chk("bb1 b0 w1a", 64'(w1_addr), 64'h1111);
    chk("bb1 b0 w1d", w1_data, 64'h3000_2000_1000_0000);
    chk("bb1 ready", 64'(in_ready), 64'd0);
    step();
    chk("bb1 b1 ready", 64'(in_ready), 64'd0);
    step();
    chk_done("bb1", 16'h001E);
    in_rD = 4'd2; in_data = pat(8'h55);
    step();
    in_rD = 4'd9; in_data = ~pat(8'h55);
    chk("bb2 b0 w1a", 64'(w1_addr), 64'h2222);
    chk("bb2 b0 w2d", w2_data, 64'h3155_2155_1155_0155);
    step();
    chk("bb2 b1 w1d", w1_data, 64'h3355_2355_1355_0355);
    step();
    chk_done("bb2", 16'h003C);
    in_rD = 4'd3; in_data = pat(8'hA0);
    step();
    in_valid = 1'b0; in_data = '0;
    chk("bb3 b0 w3a", 64'(w3_addr), 64'h5555);
    chk("bb3 b0 w3d", w3_data, 64'h32A0_22A0_12A0_02A0);
    step();
    step();
    chk_done("bb3", 16'h0078);
    step();
    chk_idle("postbb");

    // reset during BEAT1 aborts
    in_valid = 1'b1; in_rD = 4'd8; in_mask = 4'hF; in_data = pat(8'h00);
    step();
    in_valid = 1'b0;
    step();
    chk("ab b1 we", 64'(w1_we), 64'hF);
    rst_n = 1'b0;
    #1;
    chk_idle("abrst");
    step();
    rst_n = 1'b1;
    step();
    chk_idle("abpost");
    in_valid = 1'b1; in_rD = 4'd0; in_mask = 4'hF; in_data = pat(8'h00);
    step();
    in_valid = 1'b0;
    chk("ab2 w1a", 64'(w1_addr), 64'h0000);
    chk("ab2 w2a", 64'(w2_addr), 64'h1111);
    chk("ab2 w3a", 64'(w3_addr), 64'h2222);
    chk("ab2 we", 64'({w1_we, w2_we, w3_we}), 64'hFFF);
    step();
    step();
    chk_done("ab2", 16'h000F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
